// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the two requester handshakes and the memory-side strobes shared
// by mem_arbiter.
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requests into the arbiter
//   done0/done1, rdata0/rdata1                     : completion and read data
//   busy                                           : arbiter not idle
//   mem_address, mem_data_in, mem_flag_read,
//   mem_flag_write                                 : strobes to the memory
//   mem_output                                     : registered memory output
//   err0/err1 (MEM_ARB_BOUNDS_CHECK_EN only)       : out-of-range access flags
// Modports: slave = arbiter side, master = requesters plus memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              busy;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_flag_read;
  logic              mem_flag_write;
  logic [DATA_W-1:0] mem_output;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
  logic              err0;
  logic              err1;
`endif

  modport slave (
`ifdef MEM_ARB_BOUNDS_CHECK_EN
    output err0, err1,
`endif
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_output,
    output done0, done1, rdata0, rdata1, busy,
    output mem_address, mem_data_in, mem_flag_read, mem_flag_write
  );

  modport master (
`ifdef MEM_ARB_BOUNDS_CHECK_EN
    input  err0, err1,
`endif
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_output,
    input  done0, done1, rdata0, rdata1, busy,
    input  mem_address, mem_data_in, mem_flag_read, mem_flag_write
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port memory between port 0 (instruction fetch) and
// port 1 (load/store). Each access walks IDLE -> ISSUE -> WAIT -> IDLE:
// the winning request is latched in IDLE, the memory strobe is driven for
// the single ISSUE cycle, and the registered memory output is captured on
// the WAIT exit edge together with a one-cycle done pulse.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : mem_arbiter_if.slave (requests, done/rdata, busy, memory side)
// Parameters: ADDR_W, DATA_W, DEPTH (bounds check only),
//   FIXED_PRIO (0 = round-robin, 1 = port 0 wins ties).
// Optional feature: define MEM_ARB_BOUNDS_CHECK_EN to add err0/err1 and
//   suppress memory strobes for addresses >= DEPTH.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 32,
  parameter int FIXED_PRIO = 0
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t            r_state;
  logic              r_lastGrant;
  logic              r_port;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_flagRead;
  logic              r_flagWrite;
  logic              r_busy;
  logic              r_done0;
  logic              r_done1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
  logic              r_oob;
  logic              r_err0;
  logic              r_err1;
`endif

  logic              w_elig0;
  logic              w_elig1;
  logic              w_grant;
  logic              w_pick1;
  logic [ADDR_W-1:0] w_selAddr;
  logic [DATA_W-1:0] w_selWdata;
  logic              w_selWe;
  logic              w_inRange;
  logic              w_capture;
  logic [DATA_W-1:0] w_capData;

  // A port whose done pulse is high right now still holds req; masking it
  // keeps the same request from being served twice.
  assign w_elig0 = bus.req0 & ~r_done0;
  assign w_elig1 = bus.req1 & ~r_done1;
  assign w_grant = w_elig0 | w_elig1;

  // Tie break: round-robin picks the port that did not win last time.
  always_comb begin
    w_pick1 = w_elig1;
    if (w_elig0 && w_elig1) begin
      w_pick1 = (FIXED_PRIO != 0) ? 1'b0 : ~r_lastGrant;
    end
  end

  assign w_selAddr  = w_pick1 ? bus.addr1  : bus.addr0;
  assign w_selWdata = w_pick1 ? bus.wdata1 : bus.wdata0;
  assign w_selWe    = w_pick1 ? bus.we1    : bus.we0;

`ifdef MEM_ARB_BOUNDS_CHECK_EN
  // Out-of-range accesses still walk the FSM but never strobe the memory
  // and return zero data.
  assign w_inRange = (w_selAddr < ADDR_W'(DEPTH));
  assign w_capture = ~r_we | r_oob;
  assign w_capData = r_oob ? '0 : bus.mem_output;
`else
  assign w_inRange = 1'b1;
  assign w_capture = ~r_we;
  assign w_capData = bus.mem_output;
`endif

  // Single FSM; every output is a register so the memory strobes are
  // glitch-free and drop immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_lastGrant <= 1'b1;
      r_port      <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_flagRead  <= 1'b0;
      r_flagWrite <= 1'b0;
      r_busy      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
      r_oob       <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
`endif
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_addr      <= w_selAddr;
            r_wdata     <= w_selWdata;
            r_we        <= w_selWe;
            r_port      <= w_pick1;
            r_lastGrant <= w_pick1;
            r_flagRead  <= ~w_selWe & w_inRange;
            r_flagWrite <= w_selWe & w_inRange;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
            r_oob       <= ~w_inRange;
`endif
            r_busy      <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_flagRead  <= 1'b0;
          r_flagWrite <= 1'b0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (r_port) begin
            r_done1 <= 1'b1;
            if (w_capture) r_rdata1 <= w_capData;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
            r_err1  <= r_oob;
`endif
          end else begin
            r_done0 <= 1'b1;
            if (w_capture) r_rdata0 <= w_capData;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
            r_err0  <= r_oob;
`endif
          end
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_address    = r_addr;
  assign bus.mem_data_in    = r_wdata;
  assign bus.mem_flag_read  = r_flagRead;
  assign bus.mem_flag_write = r_flagWrite;
  assign bus.busy           = r_busy;
  assign bus.done0          = r_done0;
  assign bus.done1          = r_done1;
  assign bus.rdata0         = r_rdata0;
  assign bus.rdata1         = r_rdata1;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
  assign bus.err0           = r_err0;
  assign bus.err1           = r_err1;
`endif

endmodule
